// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NUM_CH independent period timers, each TOGGLE, PULSE or retriggerable ONESHOT.
// Optional shared clock-enable prescaler when MTG_PRESCALE_EN is defined.
module multi_tick_gen #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 10,
  parameter int PRESCALE       = 25,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Enable,
  input  logic [NUM_CH-1:0] i_Start,
  input  logic              i_Load,
  input  logic [CH_W-1:0]   i_Load_Ch,
  input  logic [CNT_W-1:0]  i_Load_Period,
  input  logic [1:0]        i_Load_Mode,
  output logic [NUM_CH-1:0] o_Toggle,
  output logic [NUM_CH-1:0] o_Pulse,
  output logic [NUM_CH-1:0] o_Busy,
  output logic [NUM_CH-1:0] o_Done
);

  typedef enum logic [1:0] {MODE_TOGGLE = 2'd0, MODE_PULSE = 2'd1, MODE_ONESHOT = 2'd2} mode_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  logic [CNT_W-1:0] period_q [NUM_CH];
  logic [CNT_W-1:0] period_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_d    [NUM_CH];
  mode_e            mode_q   [NUM_CH];
  mode_e            mode_d   [NUM_CH];
  state_e           state_q  [NUM_CH];
  state_e           state_d  [NUM_CH];
  logic [NUM_CH-1:0] load_sel, step_ok, term_ev;
  logic [NUM_CH-1:0] tog_d, pulse_d, busy_d, done_d;
  logic              adv_tick;

`ifdef MTG_PRESCALE_EN
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PRE_W-1:0] pre_q;

  assign adv_tick = (pre_q == PRE_W'(PRESCALE - 1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L || adv_tick) pre_q <= '0;
    else                      pre_q <= pre_q + 1'b1;
  end
`else
  assign adv_tick = 1'b1;
`endif

  // A zero period never advances, so the counter sits at 0 and no terminal count occurs.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      load_sel[c] = i_Load && (int'(i_Load_Ch) == c);
      step_ok[c]  = adv_tick && (period_q[c] != '0);
      term_ev[c]  = step_ok[c] && (cnt_q[c] == period_q[c] - 1'b1);
    end
  end

  // Next state: load > disable > start > count.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      period_d[c] = period_q[c];
      mode_d[c]   = mode_q[c];
      cnt_d[c]    = cnt_q[c];
      state_d[c]  = state_q[c];
      if (load_sel[c]) begin
        period_d[c] = i_Load_Period;
        mode_d[c]   = (i_Load_Mode == 2'd3) ? MODE_TOGGLE : mode_e'(i_Load_Mode);
        cnt_d[c]    = '0;
        state_d[c]  = ST_IDLE;
      end else if (!i_Enable[c]) begin
        cnt_d[c]   = '0;
        state_d[c] = ST_IDLE;
      end else if (mode_q[c] == MODE_ONESHOT) begin
        if (i_Start[c]) begin
          cnt_d[c]   = '0;
          state_d[c] = ST_RUN;
        end else if (state_q[c] == ST_RUN && step_ok[c]) begin
          if (term_ev[c]) begin
            cnt_d[c]   = '0;
            state_d[c] = ST_DONE;
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end
      end else if (step_ok[c]) begin
        cnt_d[c] = term_ev[c] ? '0 : cnt_q[c] + 1'b1;
      end
    end
  end

  // Outputs: next values of the registered output flops.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      tog_d[c]   = o_Toggle[c];
      pulse_d[c] = 1'b0;
      busy_d[c]  = (state_d[c] == ST_RUN);
      done_d[c]  = (state_d[c] == ST_DONE);
      if (load_sel[c] || !i_Enable[c]) begin
        tog_d[c] = 1'b0;
      end else begin
        case (mode_q[c])
          MODE_TOGGLE:  if (term_ev[c]) tog_d[c] = ~o_Toggle[c];
          MODE_PULSE:   pulse_d[c] = term_ev[c];
          MODE_ONESHOT: pulse_d[c] = term_ev[c] && !i_Start[c] && (state_q[c] == ST_RUN);
          default:      pulse_d[c] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      for (int c = 0; c < NUM_CH; c++) begin
        period_q[c] <= CNT_W'(DEFAULT_PERIOD);
        mode_q[c]   <= MODE_TOGGLE;
        cnt_q[c]    <= '0;
        state_q[c]  <= ST_IDLE;
      end
      o_Toggle <= '0;
      o_Pulse  <= '0;
      o_Busy   <= '0;
      o_Done   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        period_q[c] <= period_d[c];
        mode_q[c]   <= mode_d[c];
        cnt_q[c]    <= cnt_d[c];
        state_q[c]  <= state_d[c];
      end
      o_Toggle <= tog_d;
      o_Pulse  <= pulse_d;
      o_Busy   <= busy_d;
      o_Done   <= done_d;
    end
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Bench for multi_tick_gen: directed corner sequences, a table of per-channel scenarios,
// and a randomized run against an event-counting reference model.
module tb_multi_tick_gen;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;
  localparam int CH_W   = 2;
`ifdef MTG_PRESCALE_EN
  localparam int PRESCALE = 25;
`endif

  logic              i_Clk = 1'b0;
  logic              i_Rst_L;
  logic [NUM_CH-1:0] i_Enable, i_Start;
  logic              i_Load;
  logic [CH_W-1:0]   i_Load_Ch;
  logic [CNT_W-1:0]  i_Load_Period;
  logic [1:0]        i_Load_Mode;
  logic [NUM_CH-1:0] o_Toggle, o_Pulse, o_Busy, o_Done;

  always #5 i_Clk = ~i_Clk;

  multi_tick_gen u_dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Enable(i_Enable), .i_Start(i_Start),
    .i_Load(i_Load), .i_Load_Ch(i_Load_Ch), .i_Load_Period(i_Load_Period),
    .i_Load_Mode(i_Load_Mode), .o_Toggle(o_Toggle), .o_Pulse(o_Pulse),
    .o_Busy(o_Busy), .o_Done(o_Done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: per channel, n counts advancing cycles since the last clear;
  // an event is every P-th of them. st: 0 idle, 1 running, 2 done.
  int m_p [NUM_CH];
  int m_mode [NUM_CH];
  int m_n [NUM_CH];
  int m_st [NUM_CH];
  bit m_tog [NUM_CH];
  bit m_pul [NUM_CH];
`ifdef MTG_PRESCALE_EN
  int m_pre = 0;
`endif

  function automatic void m_clear(input int c);
    m_n[c]   = 0;
    m_st[c]  = 0;
    m_tog[c] = 1'b0;
  endfunction

  function automatic void model_step();
    bit tk;
`ifdef MTG_PRESCALE_EN
    tk    = (m_pre == PRESCALE - 1);
    m_pre = i_Rst_L ? (m_pre + 1) % PRESCALE : 0;
`else
    tk = 1'b1;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      m_pul[c] = 1'b0;
      if (!i_Rst_L) begin
        m_p[c] = 10; m_mode[c] = 0; m_clear(c);
      end else if (i_Load && int'(i_Load_Ch) == c) begin
        m_p[c]    = int'(i_Load_Period);
        m_mode[c] = (i_Load_Mode == 2'd3) ? 0 : int'(i_Load_Mode);
        m_clear(c);
      end else if (!i_Enable[c]) begin
        m_clear(c);
      end else if (m_mode[c] == 2) begin
        if (i_Start[c]) begin
          m_st[c] = 1; m_n[c] = 0;
        end else if (m_st[c] == 1 && tk && m_p[c] != 0) begin
          m_n[c]++;
          if (m_n[c] == m_p[c]) begin m_pul[c] = 1'b1; m_st[c] = 2; end
        end
      end else if (tk && m_p[c] != 0) begin
        m_n[c]++;
        if (m_n[c] % m_p[c] == 0) begin
          if (m_mode[c] == 0) m_tog[c] = ~m_tog[c];
          else                m_pul[c] = 1'b1;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    i_Rst_L = 1'b0; i_Enable = '0; i_Start = '0; i_Load = 1'b0;
    step();
    i_Rst_L = 1'b1;
  endtask

  task automatic do_load(input int ch, input int p, input int m);
    i_Load = 1'b1; i_Load_Ch = CH_W'(ch); i_Load_Period = CNT_W'(p); i_Load_Mode = 2'(m);
    step();
    i_Load = 1'b0;
  endtask

  typedef struct {
    int ch; int p; int m; int n; int st;
    int pul; int flp; int bsy; int tog; int dn;
  } vec_t;
  vec_t tbl [9];

  initial begin
    logic [NUM_CH-1:0] et, ep, eb, ed;
    int pulses, flips, busyc, other;
    logic prev;

    i_Rst_L = 1'b0; i_Enable = '0; i_Start = '0; i_Load = 1'b0;
    i_Load_Ch = '0; i_Load_Period = '0; i_Load_Mode = '0;
    for (int c = 0; c < NUM_CH; c++) begin m_p[c] = 10; m_mode[c] = 0; m_clear(c); m_pul[c] = 0; end

    // Reset state
    step(); step();
    chk("reset_toggle", o_Toggle, 0);
    chk("reset_pulse", o_Pulse, 0);
    chk("reset_busy", o_Busy, 0);
    chk("reset_done", o_Done, 0);
    i_Rst_L = 1'b1;

    // Default period 10 toggle timing on ch0
    do_reset();
    i_Enable = 4'b0001;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 9)  chk("tog_before_10", o_Toggle[0], 0);
      if (k == 10) chk("tog_rise_10", o_Toggle[0], 1);
      if (k == 19) chk("tog_hold_19", o_Toggle[0], 1);
      if (k == 20) chk("tog_fall_20", o_Toggle[0], 0);
    end
    chk("tog_others_zero", o_Toggle[3:1], 0);

    // Disable mid-count clears the counter
    do_reset();
    do_load(1, 3, 1);
    i_Enable = 4'b0010;
    step(); step();
    chk("dis_pre_pulse", o_Pulse[1], 0);
    i_Enable = 4'b0000; step();
    i_Enable = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("dis_reen_%0d", k), o_Pulse[1], (k == 3) ? 1 : 0);
    end

    // One-shot with retrigger, start on terminal count, and DONE restart
    do_reset();
    do_load(2, 5, 2);
    i_Enable = 4'b0100;
    i_Start = 4'b0100; step(); i_Start = '0;
    chk("os_busy_start", o_Busy[2], 1);
    repeat (3) step();
    i_Start = 4'b0100; step(); i_Start = '0;
    chk("os_retrig_nopulse", o_Pulse[2], 0);
    chk("os_retrig_busy", o_Busy[2], 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("os_retrig_pulse_%0d", k), o_Pulse[2], (k == 5) ? 1 : 0);
    end
    chk("os_done_sticky", o_Done[2], 1);
    chk("os_done_notbusy", o_Busy[2], 0);
    step();
    chk("os_done_hold", o_Done[2], 1);
    i_Start = 4'b0100; step(); i_Start = '0;
    chk("os_restart_clrdone", o_Done[2], 0);
    chk("os_restart_busy", o_Busy[2], 1);
    repeat (4) step();
    i_Start = 4'b0100; step(); i_Start = '0;
    chk("os_tc_start_nopulse", o_Pulse[2], 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("os_tc_pulse_%0d", k), o_Pulse[2], (k == 5) ? 1 : 0);
    end
    i_Enable = '0; step();
    chk("os_dis_clrdone", o_Done[2], 0);
    i_Start = 4'b0100; step(); i_Start = '0;
    chk("os_start_ignored", o_Busy[2], 0);

    // Load on the terminal-count cycle
    do_reset();
    i_Enable = 4'b0001;
    repeat (9) step();
    do_load(0, 4, 0);
    chk("load_tc_notoggle", o_Toggle[0], 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("load_newp_%0d", k), o_Toggle[0], (k == 4) ? 1 : 0);
    end

    // Reset mid-run drops everything
    do_reset();
    do_load(2, 5, 2);
    do_load(1, 1, 1);
    i_Enable = 4'b0110;
    i_Start = 4'b0100; step(); i_Start = '0;
    step();
    chk("midrst_pre_busy", o_Busy[2], 1);
    chk("midrst_pre_pulse", o_Pulse[1], 1);
    i_Rst_L = 1'b0; step();
    chk("midrst_toggle", o_Toggle, 0);
    chk("midrst_pulse", o_Pulse, 0);
    chk("midrst_busy", o_Busy, 0);
    i_Rst_L = 1'b1;

    // Table: {ch, P, mode, cycles, start, pulses, flips, busy cycles, final toggle, final done}
    tbl[0] = '{0, 10, 0, 25, 0, 0, 2, 0, 0, 0};
    tbl[1] = '{1,  3, 1,  9, 0, 3, 0, 0, 0, 0};
    tbl[2] = '{2,  5, 2, 12, 1, 1, 0, 5, 0, 1};
    tbl[3] = '{3,  0, 1, 50, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{3,  0, 0, 50, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{1,  1, 1,  8, 0, 8, 0, 0, 0, 0};
    tbl[6] = '{0,  1, 0,  7, 0, 0, 7, 0, 1, 0};
    tbl[7] = '{2,  4, 3,  8, 0, 0, 2, 0, 0, 0};
    tbl[8] = '{3,  2, 2, 10, 1, 1, 0, 2, 0, 1};
    for (int r = 0; r < 9; r++) begin
      do_reset();
      do_load(tbl[r].ch, tbl[r].p, tbl[r].m);
      i_Enable = NUM_CH'(1) << tbl[r].ch;
      i_Start  = tbl[r].st != 0 ? NUM_CH'(1) << tbl[r].ch : '0;
      pulses = 0; flips = 0; busyc = 0; other = 0; prev = o_Toggle[tbl[r].ch];
      for (int k = 0; k < tbl[r].n; k++) begin
        step();
        i_Start = '0;
        pulses += int'(o_Pulse[tbl[r].ch]);
        flips  += int'(o_Toggle[tbl[r].ch] != prev);
        prev    = o_Toggle[tbl[r].ch];
        busyc  += int'(o_Busy[tbl[r].ch]);
        if (((o_Toggle | o_Pulse | o_Busy | o_Done) & ~i_Enable) != 0) other++;
      end
      chk($sformatf("tbl%0d_pulses", r), pulses, tbl[r].pul);
      chk($sformatf("tbl%0d_flips", r), flips, tbl[r].flp);
      chk($sformatf("tbl%0d_busy", r), busyc, tbl[r].bsy);
      chk($sformatf("tbl%0d_toggle", r), o_Toggle[tbl[r].ch], tbl[r].tog);
      chk($sformatf("tbl%0d_done", r), o_Done[tbl[r].ch], tbl[r].dn);
      chk($sformatf("tbl%0d_others", r), other, 0);
    end

    // Randomized run against the model
    do_reset();
    i_Enable = 4'b1111;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_Rst_L = ($urandom_range(0, 499) != 0);
      i_Load  = ($urandom_range(0, 19) == 0);
      i_Load_Ch     = CH_W'($urandom_range(0, NUM_CH - 1));
      i_Load_Period = CNT_W'($urandom_range(0, 6));
      i_Load_Mode   = 2'($urandom_range(0, 3));
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 29) == 0) i_Enable[c] = ~i_Enable[c];
        i_Start[c] = ($urandom_range(0, 7) == 0);
      end
      step();
      for (int c = 0; c < NUM_CH; c++) begin
        et[c] = m_tog[c]; ep[c] = m_pul[c];
        eb[c] = (m_st[c] == 1); ed[c] = (m_st[c] == 2);
      end
      chk($sformatf("rnd%0d_toggle", cyc), o_Toggle, et);
      chk($sformatf("rnd%0d_pulse", cyc), o_Pulse, ep);
      chk($sformatf("rnd%0d_busy", cyc), o_Busy, eb);
      chk($sformatf("rnd%0d_done", cyc), o_Done, ed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
